// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parameterised accumulator CPU with a program-load mode.
// Define ACC_CPU_STEP_EN to add a Step input that gates FETCH -> EXEC.
module acc_cpu_param #(
  parameter int DW = 8,
  parameter int AW = 5,
  localparam int IW = 3 + AW,
  localparam int LW = (IW > DW) ? IW : DW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Load,
  input  logic          Ld_valid,
  input  logic          Ld_sel,
  input  logic [LW-1:0] Ld_data,
`ifdef ACC_CPU_STEP_EN
  input  logic          Step,
`endif
  output logic [AW-1:0] Pc,
  output logic [IW-1:0] Instruction,
  output logic [DW-1:0] Acc,
  output logic          Halted,
  output logic          Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t state_q, state_d;

  logic [IW-1:0] imem [0:2**AW-1];
  logic [DW-1:0] dmem [0:2**AW-1];

  logic [AW-1:0] iptr, dptr;
  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic [DW-1:0] mval;
  logic [DW-1:0] acc_d;
  logic [AW-1:0] pc_d;
  logic          exec;
  logic          ld_we;
  logic          step_ok;

`ifdef ACC_CPU_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  assign op    = Instruction[IW-1:AW];
  assign addr  = Instruction[AW-1:0];
  assign mval  = dmem[addr];
  // A Load request in the same cycle cancels the instruction outright
  assign exec  = (state_q == S_EXEC) && !Load;
  assign ld_we = (state_q == S_LOAD) && Load && Ld_valid;

  assign Halted = (state_q == S_HALT);
  assign Busy   = (state_q == S_FETCH) || (state_q == S_EXEC);

  always_comb begin
    state_d = state_q;
    if (Load) begin
      state_d = S_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_LOAD:  state_d = S_FETCH;
        S_FETCH: if (step_ok) state_d = S_EXEC;
        S_EXEC:  state_d = (op == OP_HLT) ? S_HALT : S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d = Acc;
    pc_d  = Pc + AW'(1);
    unique case (op)
      OP_HLT: pc_d  = Pc;
      OP_SKZ: pc_d  = (Acc == '0) ? Pc + AW'(2) : Pc + AW'(1);
      OP_ADD: acc_d = Acc + mval;
      OP_AND: acc_d = Acc & mval;
      OP_XOR: acc_d = Acc ^ mval;
      OP_LDA: acc_d = mval;
      OP_STO: acc_d = Acc;
      OP_JMP: pc_d  = addr;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      Pc          <= '0;
      Instruction <= '0;
      Acc         <= '0;
      iptr        <= '0;
      dptr        <= '0;
    end else begin
      state_q <= state_d;
      if (Load && state_q != S_LOAD) begin
        iptr <= '0;
        dptr <= '0;
      end else if (ld_we) begin
        if (Ld_sel) dptr <= dptr + AW'(1);
        else        iptr <= iptr + AW'(1);
      end
      if (state_q == S_LOAD) Pc <= '0;
      if (state_q == S_FETCH && !Load) begin
        Instruction <= imem[Pc];
      end
      if (exec) begin
        Pc  <= pc_d;
        Acc <= acc_d;
      end
    end
  end

  // Memories are deliberately outside the reset domain
  always_ff @(posedge Clk) begin
    if (ld_we && !Ld_sel) imem[iptr] <= Ld_data[IW-1:0];
    if (ld_we && Ld_sel) begin
      dmem[dptr] <= Ld_data[DW-1:0];
    end else if (exec && op == OP_STO) begin
      dmem[addr] <= Acc;
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: default build plus a DW=16/AW=8 copy.
module tb_acc_cpu_param;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Load = 1'b0;
  logic        Ld_valid = 1'b0;
  logic        Ld_sel = 1'b0;
  logic [7:0]  Ld_data = '0;
  logic [4:0]  Pc;
  logic [7:0]  Instruction;
  logic [7:0]  Acc;
  logic        Halted;
  logic        Busy;

  logic        b_Load = 1'b1;
  logic        b_Ld_valid = 1'b0;
  logic        b_Ld_sel = 1'b0;
  logic [15:0] b_Ld_data = '0;
  logic [7:0]  b_Pc;
  logic [10:0] b_Instruction;
  logic [15:0] b_Acc;
  logic        b_Halted;
  logic        b_Busy;

  int checks = 0;
  int errors = 0;

`ifdef ACC_CPU_STEP_EN
  logic Step = 1'b1;
`endif

  always #5 Clk = ~Clk;

  acc_cpu_param dut (
    .Clk(Clk), .Reset(Reset), .Load(Load),
    .Ld_valid(Ld_valid), .Ld_sel(Ld_sel),
    .Ld_data(Ld_data),
`ifdef ACC_CPU_STEP_EN
    .Step(Step),
`endif
    .Pc(Pc), .Instruction(Instruction),
    .Acc(Acc), .Halted(Halted), .Busy(Busy)
  );

  acc_cpu_param #(.DW(16), .AW(8)) big (
    .Clk(Clk), .Reset(Reset), .Load(b_Load),
    .Ld_valid(b_Ld_valid), .Ld_sel(b_Ld_sel),
    .Ld_data(b_Ld_data),
`ifdef ACC_CPU_STEP_EN
    .Step(Step),
`endif
    .Pc(b_Pc), .Instruction(b_Instruction),
    .Acc(b_Acc), .Halted(b_Halted), .Busy(b_Busy)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op,
                                     input logic [4:0] a);
    return {op, a};
  endfunction

  task automatic wr(input logic sel, input logic [7:0] d);
    Ld_sel = sel;
    Ld_data = d;
    Ld_valid = 1'b1;
    tick();
    Ld_valid = 1'b0;
  endtask

  task automatic begin_load;
    Load = 1'b1;
    tick();
  endtask

  task automatic end_load;
    Load = 1'b0;
    tick();
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!Halted && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(Halted), 32'd1);
  endtask

  initial begin
    Load = 1'b1;
    #1 Reset = 1'b1;
    #1;
    check("rst_pc", 32'(Pc), 32'h0);
    check("rst_acc", 32'(Acc), 32'h0);
    check("rst_ir", 32'(Instruction), 32'h0);
    check("rst_halted", 32'(Halted), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    tick(2);
    Reset = 1'b0;
    tick();

    // LDA 1, ADD 2, STO 3, HLT
    wr(0, ins(3'b101, 5'd1));
    wr(0, ins(3'b010, 5'd2));
    wr(0, ins(3'b110, 5'd3));
    wr(0, ins(3'b000, 5'd0));
    wr(1, 8'h00);
    wr(1, 8'h05);
    wr(1, 8'h0A);
    wr(1, 8'h00);
    end_load;
    check("run_busy", 32'(Busy), 32'h1);
    tick(8);
    check("prog_halted", 32'(Halted), 32'h1);
    check("prog_acc", 32'(Acc), 32'h0F);
    check("prog_dmem3", 32'(dut.dmem[3]), 32'h0F);
    check("prog_pc", 32'(Pc), 32'h3);
    check("halt_busy", 32'(Busy), 32'h0);

    // SKZ at 4 with Acc zero / nonzero
    begin_load;
    wr(0, ins(3'b101, 5'd0));
    wr(0, ins(3'b111, 5'd4));
    wr(0, ins(3'b000, 5'd0));
    wr(0, ins(3'b000, 5'd0));
    wr(0, ins(3'b001, 5'd0));
    wr(0, ins(3'b000, 5'd0));
    wr(0, ins(3'b000, 5'd0));
    wr(1, 8'h00);
    end_load;
    check("load_keeps_acc", 32'(Acc), 32'h0F);
    check("load_pc0", 32'(Pc), 32'h0);
    wait_halt("skz0_halt");
    check("skz0_pc", 32'(Pc), 32'h6);
    check("skz0_acc", 32'(Acc), 32'h0);

    begin_load;
    wr(1, 8'h01);
    end_load;
    wait_halt("skz1_halt");
    check("skz1_pc", 32'(Pc), 32'h5);

    // SKZ at 31 wraps to 1
    begin_load;
    wr(1, 8'h00);
    for (int i = 0; i < 32; i++) begin
      if (i == 0)       wr(0, ins(3'b101, 5'd0));
      else if (i == 1)  wr(0, ins(3'b111, 5'd31));
      else if (i == 31) wr(0, ins(3'b001, 5'd0));
      else              wr(0, ins(3'b000, 5'd0));
    end
    end_load;
    tick(4);
    check("skz31_at", 32'(Pc), 32'd31);
    tick(2);
    check("skz31_wrap", 32'(Pc), 32'd1);

    // ADD wrap, JMP 31 then fall-through wraps to 0
    begin_load;
    wr(1, 8'hFF);
    wr(1, 8'h02);
    wr(1, 8'h00);
    for (int i = 0; i < 32; i++) begin
      if (i == 0)       wr(0, ins(3'b101, 5'd0));
      else if (i == 1)  wr(0, ins(3'b010, 5'd1));
      else if (i == 2)  wr(0, ins(3'b111, 5'd31));
      else if (i == 31) wr(0, ins(3'b100, 5'd2));
      else              wr(0, ins(3'b000, 5'd0));
    end
    end_load;
    tick(4);
    check("add_wrap_acc", 32'(Acc), 32'h01);
    check("add_wrap_pc", 32'(Pc), 32'h2);
    tick(2);
    check("jmp31_pc", 32'(Pc), 32'd31);
    tick(2);
    check("pc_wrap0", 32'(Pc), 32'd0);

    // Load arriving during EXEC of STO 7 aborts it
    begin_load;
    wr(1, 8'hAA);
    for (int i = 1; i < 7; i++) wr(1, 8'h00);
    wr(1, 8'h33);
    wr(0, ins(3'b101, 5'd0));
    wr(0, ins(3'b110, 5'd7));
    end_load;
    tick(3);
    check("sto_in_exec", 32'(Busy), 32'h1);
    Load = 1'b1;
    tick();
    check("abort_dmem7", 32'(dut.dmem[7]), 32'h33);
    check("abort_acc", 32'(Acc), 32'hAA);
    check("abort_pc", 32'(Pc), 32'h1);
    check("abort_busy", 32'(Busy), 32'h0);
    check("abort_halted", 32'(Halted), 32'h0);
    check("abort_iptr", 32'(dut.iptr), 32'h0);
    check("abort_dptr", 32'(dut.dptr), 32'h0);
    wr(1, 8'h5C);
    check("abort_loadw", 32'(dut.dmem[0]), 32'h5C);

    // Reset in the middle of EXEC of ADD
    wr(1, 8'h04);
    wr(0, ins(3'b101, 5'd0));
    wr(0, ins(3'b010, 5'd1));
    wr(0, ins(3'b000, 5'd0));
    end_load;
    tick(3);
    check("pre_rst_acc", 32'(Acc), 32'h5C);
    Reset = 1'b1;
    #1;
    check("midrst_acc", 32'(Acc), 32'h0);
    check("midrst_pc", 32'(Pc), 32'h0);
    check("midrst_busy", 32'(Busy), 32'h0);
    tick();
    Reset = 1'b0;
    wait_halt("rerun_halt");
    check("rerun_acc", 32'(Acc), 32'h60);
    check("rerun_pc", 32'(Pc), 32'h2);

    // DW=16 / AW=8 instance
    tick();
    b_Ld_sel = 1'b1;
    b_Ld_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      b_Ld_data = (i == 0) ? 16'h0001 : 16'h0000;
      tick();
    end
    b_Ld_valid = 1'b0;
    check("big_dptr33", 32'(big.dptr), 32'd33);
    b_Ld_sel = 1'b0;
    b_Ld_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 0)        b_Ld_data = 16'({3'b010, 8'h00});
      else if (i == 1)   b_Ld_data = 16'({3'b111, 8'hFF});
      else if (i == 255) b_Ld_data = 16'({3'b111, 8'h00});
      else               b_Ld_data = 16'h0000;
      tick();
    end
    b_Ld_valid = 1'b0;
    check("big_iptr_wrap", 32'(big.iptr), 32'd0);
    check("big_imem255", 32'(big.imem[255]), 32'h700);
    b_Load = 1'b0;
    tick();
    tick(4);
    check("big_pc255", 32'(b_Pc), 32'd255);
    tick(14);
    check("big_loop_pc", 32'(b_Pc), 32'd0);
    check("big_loop_acc", 32'(b_Acc), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
